mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_pkg.sv | 13 +
 rtl/defines.sv | 4 +
 rtl/mem_timeout_ctr.sv | 31 +++
 rtl/mem_access_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and default parameters for the memory access controller.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_ADDR_W         = 12;
  localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/defines.sv
// Global word-width define shared by the datapath and the memory access block.
`ifndef WORD_LEN
`define WORD_LEN 16
`endif

// File: rtl/mem_timeout_ctr.sv
// BUSY-cycle watchdog: counts enabled cycles from a clear and flags the last
// allowed cycle. Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr
  import mem_access_pkg::*;
#(
  parameter int CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int                CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Saturates on LAST so a stuck enable can never wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer (IDLE -> BUSY -> DONE) between the EX/MEM
// register and a req/ack memory port. Optional BUSY timeout: MEM_TIMEOUT_EN.
`ifndef WORD_LEN
`include "defines.sv"
`endif

module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PR3_MEM_read,
  input  logic                 PR3_MEM_write,
  input  logic [`WORD_LEN-1:0] PR3_alu_out,
  input  logic [`WORD_LEN-1:0] PR3_RF_out2,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [`WORD_LEN-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [`WORD_LEN-1:0] mem_rdata,
  output logic                 MEM_stall,
  output logic [`WORD_LEN-1:0] MEM_rdata,
  output logic                 MEM_rdata_valid,
  output logic                 MEM_error
);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic                   r_we;
  logic [ADDR_W-1:0]      r_addr;
  logic [`WORD_LEN-1:0]   r_wdata;
  logic [`WORD_LEN-1:0]   r_rdata;
  logic                   r_rd_valid;

  logic w_req_in;
  logic w_busy;
  logic w_accept;
  logic w_ack_busy;
  logic w_expired;
  logic w_abort;

  assign w_req_in   = PR3_MEM_read | PR3_MEM_write;
  assign w_busy     = (r_state == BUSY);
  assign w_accept   = (r_state == IDLE) && w_req_in;
  assign w_ack_busy = w_busy && mem_ack;
  assign w_abort    = w_busy && !mem_ack && w_expired;

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_req_in) w_state_nxt = BUSY;
      BUSY:    if (mem_ack || w_abort) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr  <= PR3_alu_out[ADDR_W-1:0];
        r_wdata <= PR3_RF_out2;
        r_we    <= PR3_MEM_write;
      end
      if (w_ack_busy && !r_we) begin
        r_rdata <= mem_rdata;
      end
      r_rd_valid <= w_ack_busy && !r_we;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic r_error;

  mem_timeout_ctr #(
    .CYCLES    (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_accept),
    .i_enable  (w_busy),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_error <= 1'b0;
    end else begin
      r_error <= w_abort;
    end
  end

  assign MEM_error = r_error;
`else
  logic w_unused_timeout;

  assign w_expired        = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign MEM_error        = 1'b0;
`endif

  // Address bits above ADDR_W are dropped on purpose.
  generate
    if (ADDR_W < `WORD_LEN) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^PR3_alu_out[`WORD_LEN-1:ADDR_W];
    end
  endgenerate

  assign mem_req         = w_busy;
  assign mem_we          = r_we;
  assign mem_addr        = r_addr;
  assign mem_wdata       = r_wdata;
  assign MEM_stall       = w_accept || w_busy;
  assign MEM_rdata       = r_rdata;
  assign MEM_rdata_valid = r_rd_valid;

endmodule
